// File: rtl/tlv320_i2c_target_pkg.sv
// Shared types and constants for the TLV320/WM8731 write-only I2C control target.
package tlv320_i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK_1, ST_BYTE2, ST_ACK_2, ST_IGNORE
  } state_e;

  localparam logic [6:0] DEV_ADDR_TLV320 = 7'h1A;
  localparam int         REG_ADDR_W      = 7;
  localparam int         REG_DATA_W      = 9;

  // States where an own-address frame is in flight and a START/STOP means abort.
  function automatic logic frame_open(input state_e s);
    return (s == ST_ACK_A) || (s == ST_BYTE1) || (s == ST_ACK_1) || (s == ST_BYTE2);
  endfunction

  function automatic state_e ack_next(input state_e s);
    case (s)
      ST_ACK_A: return ST_BYTE1;
      ST_ACK_1: return ST_BYTE2;
      default:  return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/tlv320_i2c_target_line_filter.sv
// 2-FF synchroniser plus optional persistence filter for one I2C line.
// The filter is present only when TLV320_I2C_TARGET_GLITCH_FILT_EN is defined.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_level_d;
  logic       w_level;

  // Preset high so reset looks like an idle bus and creates no edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_raw};
  end

`ifdef TLV320_I2C_TARGET_GLITCH_FILT_EN
  logic [3:0] r_cnt;
  logic       r_filt;

  // Counts consecutive samples disagreeing with the current level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_sync[1] != r_filt) begin
      if (r_cnt == 4'(FILT_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 4'd1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_level_d <= 1'b1;
    else       r_level_d <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  =  w_level & ~r_level_d;
  assign o_fall  = ~w_level &  r_level_d;

endmodule

// File: rtl/tlv320_i2c_target.sv
// Write-only I2C target decoding the 7-bit address / 9-bit data codec control word.
// Define TLV320_I2C_TARGET_GLITCH_FILT_EN to enable the FILT_LEN persistence filter.
module tlv320_i2c_target
  import tlv320_i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_TLV320,
  parameter int         FILT_LEN = 3
) (
  input  logic                  inclk,
  input  logic                  rst,
  input  logic                  i2c_scl,
  input  logic                  i2c_sda_i,
  output logic                  i2c_sda_oe,
  output logic                  wr_valid,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_DATA_W-1:0] reg_data,
  output logic                  busy,
  output logic                  abort
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .i_clk(inclk), .i_rst(rst), .i_raw(i2c_scl),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .i_clk(inclk), .i_rst(rst), .i_raw(i2c_sda_i),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;

  state_e                r_state;
  logic [3:0]            r_bitcnt;  // bits sampled in the current byte, 0..8
  logic [7:0]            r_shift;
  logic [7:0]            r_byte1;
  logic                  r_sda_oe;
  logic                  r_wr_valid;
  logic [REG_ADDR_W-1:0] r_reg_addr;
  logic [REG_DATA_W-1:0] r_reg_data;
  logic                  r_busy;
  logic                  r_abort;

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_byte1    <= '0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_busy     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_abort    <= 1'b0;
      // Bus conditions win over any coincident SCL edge.
      if (w_start || w_stop) begin
        r_abort  <= frame_open(r_state);
        r_state  <= w_start ? ST_ADDR : ST_IDLE;
        r_busy   <= w_start;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (w_scl_rise && r_bitcnt != 4'd8) begin
              r_shift  <= {r_shift[6:0], w_sda_lvl};
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_state == ST_BYTE2 && r_bitcnt == 4'd7) begin
                r_reg_addr <= r_byte1[7:1];
                r_reg_data <= {r_byte1[0], r_shift[6:0], w_sda_lvl};
                r_wr_valid <= 1'b1;
              end
            end else if (w_scl_fall && r_bitcnt == 4'd8) begin
              r_bitcnt <= '0;
              if (r_state == ST_ADDR) begin
                if (r_shift == {DEV_ADDR, 1'b0}) begin
                  r_state  <= ST_ACK_A;
                  r_sda_oe <= 1'b1;
                end else begin
                  r_state  <= ST_IGNORE;
                end
              end else begin
                if (r_state == ST_BYTE1) r_byte1 <= r_shift;
                r_state  <= (r_state == ST_BYTE1) ? ST_ACK_1 : ST_ACK_2;
                r_sda_oe <= 1'b1;
              end
            end
          end
          ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= ack_next(r_state);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda_oe = r_sda_oe;
  assign wr_valid   = r_wr_valid;
  assign reg_addr   = r_reg_addr;
  assign reg_data   = r_reg_data;
  assign busy       = r_busy;
  assign abort      = r_abort;

endmodule

// File: tb/tb_tlv320_i2c_target.sv
// Directed bench: bit-banged I2C master against the codec control target.
module tb_tlv320_i2c_target;

  localparam int Q = 30;  // quarter SCL period in inclk cycles (~100 kHz at 12.288 MHz)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       oe, wr_valid, busy, abort;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, ab_cnt = 0, oe_cnt = 0;
  int wr0, ab0, oe0;
  logic ack;

  assign sda_line = sda_m & ~oe;

  tlv320_i2c_target #(.DEV_ADDR(7'h1A), .FILT_LEN(3)) dut (
    .inclk(clk), .rst(rst), .i2c_scl(scl_m), .i2c_sda_i(sda_line),
    .i2c_sda_oe(oe), .wr_valid(wr_valid), .reg_addr(reg_addr),
    .reg_data(reg_data), .busy(busy), .abort(abort)
  );

  always #41 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) wr_cnt++;
    if (abort)    ab_cnt++;
    if (oe)       oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    wr0 = wr_cnt; ab0 = ab_cnt; oe0 = oe_cnt;
  endtask

  // Works both from idle and as a repeated START after an ACK.
  task automatic i2c_start();
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b0; w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b1; w(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, input bit rst_ack,
                           output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; w(Q);
      if (i == glitch_bit) begin
        scl_m = 1'b1; w(2);
        scl_m = 1'b0; w(Q);
      end
      scl_m = 1'b1; w(2 * Q);
      scl_m = 1'b0; w(Q);
    end
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    a = ~sda_line;
    if (rst_ack) begin
      chk("ack1_oe_before_rst", {31'd0, oe}, 32'd1);
      rst = 1'b1; #1;
      chk("rst_oe_async", {31'd0, oe}, 32'd0);
      chk("rst_busy_async", {31'd0, busy}, 32'd0);
      w(3);
      rst = 1'b0;
    end
    w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  initial begin
    // Reset state
    w(5);
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    chk("rst_reg_addr", {25'd0, reg_addr}, 32'd0);
    chk("rst_reg_data", {23'd0, reg_data}, 32'd0);
    rst = 1'b0;
    w(10);

    // 1: 0x34,0x12,0x01 -> addr 0x09 data 0x001
    snap();
    i2c_start();
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(8'h34, -1, 1'b0, ack); chk("t1_ack_addr", {31'd0, ack}, 32'd1);
    send_byte(8'h12, -1, 1'b0, ack); chk("t1_ack_b1", {31'd0, ack}, 32'd1);
    send_byte(8'h01, -1, 1'b0, ack); chk("t1_ack_b2", {31'd0, ack}, 32'd1);
    chk("t1_busy_before_stop", {31'd0, busy}, 32'd1);
    i2c_stop(); w(Q);
    chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("t1_wr_count", wr_cnt - wr0, 32'd1);
    chk("t1_abort_count", ab_cnt - ab0, 32'd0);
    chk("t1_reg_addr", {25'd0, reg_addr}, 32'h09);
    chk("t1_reg_data", {23'd0, reg_data}, 32'h001);

    // 2: 0x34,0x08,0x15 plus extra 0xAA -> NACK on extra, single strobe
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h08, -1, 1'b0, ack);
    send_byte(8'h15, -1, 1'b0, ack); chk("t2_ack_b2", {31'd0, ack}, 32'd1);
    send_byte(8'hAA, -1, 1'b0, ack); chk("t2_nack_extra", {31'd0, ack}, 32'd0);
    i2c_stop(); w(Q);
    chk("t2_wr_count", wr_cnt - wr0, 32'd1);
    chk("t2_reg_addr", {25'd0, reg_addr}, 32'h04);
    chk("t2_reg_data", {23'd0, reg_data}, 32'h015);

    // 3: wrong address 0x36 and read address 0x35 are ignored silently
    snap();
    i2c_start();
    send_byte(8'h36, -1, 1'b0, ack); chk("t3_nack_0x36", {31'd0, ack}, 32'd0);
    send_byte(8'h12, -1, 1'b0, ack); chk("t3_nack_follow", {31'd0, ack}, 32'd0);
    i2c_stop(); w(Q);
    i2c_start();
    send_byte(8'h35, -1, 1'b0, ack); chk("t3_nack_0x35", {31'd0, ack}, 32'd0);
    i2c_stop(); w(Q);
    chk("t3_oe_never", oe_cnt - oe0, 32'd0);
    chk("t3_wr_count", wr_cnt - wr0, 32'd0);
    chk("t3_abort_count", ab_cnt - ab0, 32'd0);
    chk("t3_regs_held", {16'd0, reg_addr, reg_data}, {16'd0, 7'h04, 9'h015});

    // 4: STOP after byte1 aborts, regs held; then full frame 0x34,0x1E,0x00
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h1E, -1, 1'b0, ack);
    i2c_stop(); w(Q);
    chk("t4_abort_count", ab_cnt - ab0, 32'd1);
    chk("t4_wr_count", wr_cnt - wr0, 32'd0);
    chk("t4_reg_addr_held", {25'd0, reg_addr}, 32'h04);
    chk("t4_reg_data_held", {23'd0, reg_data}, 32'h015);
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h1E, -1, 1'b0, ack);
    send_byte(8'h00, -1, 1'b0, ack);
    i2c_stop(); w(Q);
    chk("t4b_wr_count", wr_cnt - wr0, 32'd1);
    chk("t4b_reg_addr", {25'd0, reg_addr}, 32'h0F);
    chk("t4b_reg_data", {23'd0, reg_data}, 32'h000);

    // 5: repeated START after byte1, then 0x34,0x0A,0x80
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h12, -1, 1'b0, ack);
    i2c_start();
    chk("t5_busy_rep_start", {31'd0, busy}, 32'd1);
    send_byte(8'h34, -1, 1'b0, ack); chk("t5_ack_addr2", {31'd0, ack}, 32'd1);
    send_byte(8'h0A, -1, 1'b0, ack);
    send_byte(8'h80, -1, 1'b0, ack);
    i2c_stop(); w(Q);
    chk("t5_abort_count", ab_cnt - ab0, 32'd1);
    chk("t5_wr_count", wr_cnt - wr0, 32'd1);
    chk("t5_reg_addr", {25'd0, reg_addr}, 32'h05);
    chk("t5_reg_data", {23'd0, reg_data}, 32'h080);

`ifdef TLV320_I2C_TARGET_GLITCH_FILT_EN
    // 6a: 2-cycle SCL glitch inside byte1 is filtered out
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h12, 3, 1'b0, ack); chk("t6_ack_glitch", {31'd0, ack}, 32'd1);
    send_byte(8'h01, -1, 1'b0, ack);
    i2c_stop(); w(Q);
    chk("t6_wr_count", wr_cnt - wr0, 32'd1);
    chk("t6_reg_addr", {25'd0, reg_addr}, 32'h09);
    chk("t6_reg_data", {23'd0, reg_data}, 32'h001);
`endif

    // 6b: reset during ACK_1 releases SDA at once and returns to idle
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h12, -1, 1'b1, ack);
    chk("t6b_busy_after_rst", {31'd0, busy}, 32'd0);
    i2c_stop(); w(Q);
    chk("t6b_wr_count", wr_cnt - wr0, 32'd0);
    chk("t6b_abort_count", ab_cnt - ab0, 32'd0);
    chk("t6b_regs_cleared", {16'd0, reg_addr, reg_data}, 32'd0);
    snap();
    i2c_start();
    send_byte(8'h34, -1, 1'b0, ack);
    send_byte(8'h08, -1, 1'b0, ack);
    send_byte(8'h15, -1, 1'b0, ack);
    i2c_stop(); w(Q);
    chk("t6b_post_rst_wr", wr_cnt - wr0, 32'd1);
    chk("t6b_post_rst_regs", {16'd0, reg_addr, reg_data}, {16'd0, 7'h04, 9'h015});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
